// File: rtl/block_fifo_pkg.sv
// rtl/block_fifo_pkg.sv - shared defaults, width helpers and lane mapping for block_fifo
package block_fifo_pkg;

  localparam int IN_W_DEF      = 8;
  localparam int BLK_BYTES_DEF = 64;
  localparam int DEPTH_DEF     = 256;
  localparam int GRP_DEF       = 4;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Output byte slot for block byte k (k=0 oldest); swap reverses order inside each group.
  function automatic int lane_pos(input int k, input logic swap, input int grp);
    int g;
    int p;
    g = k / grp;
    p = k % grp;
    return swap ? (g * grp + grp - 1 - p) : k;
  endfunction

endpackage

// File: rtl/block_fifo_pack.sv
// rtl/block_fifo_pack.sv - combinational row-to-block lane permutation
module block_fifo_pack
  import block_fifo_pkg::*;
#(
  parameter int IN_W      = IN_W_DEF,
  parameter int BLK_BYTES = BLK_BYTES_DEF,
  parameter int GRP       = GRP_DEF
) (
  input  logic                      swap_i,
  input  logic [BLK_BYTES*IN_W-1:0] row_i,
  output logic [BLK_BYTES*IN_W-1:0] data_o
);

  logic [BLK_BYTES*IN_W-1:0] le_w;
  logic [BLK_BYTES*IN_W-1:0] be_w;

  for (genvar k = 0; k < BLK_BYTES; k++) begin : g_lane
    localparam int LE_POS = lane_pos(k, 1'b0, GRP);
    localparam int BE_POS = lane_pos(k, 1'b1, GRP);
    assign le_w[IN_W*LE_POS +: IN_W] = row_i[IN_W*k +: IN_W];
    assign be_w[IN_W*BE_POS +: IN_W] = row_i[IN_W*k +: IN_W];
  end

  assign data_o = swap_i ? be_w : le_w;

endmodule

// File: rtl/block_fifo.sv
// rtl/block_fifo.sv - byte-in, block-out FIFO with backpressure and sticky error flags
module block_fifo
  import block_fifo_pkg::*;
#(
  parameter int IN_W      = IN_W_DEF,
  parameter int BLK_BYTES = BLK_BYTES_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int GRP       = GRP_DEF,
  parameter int CNT_W     = cnt_width(DEPTH)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_wr_en,
  input  logic [IN_W-1:0]           i_data,
  output logic                      o_full,
  input  logic                      i_rd_en,
  input  logic                      i_swap,
  output logic [BLK_BYTES*IN_W-1:0] o_data,
  output logic                      o_valid,
  output logic                      o_data_rdy,
  output logic [CNT_W-1:0]          o_data_cnt,
  input  logic                      i_clr_err,
  output logic                      o_ovf,
  output logic                      o_udf
);

  localparam int ROWS   = DEPTH / BLK_BYTES;
  localparam int LANE_W = $clog2(BLK_BYTES);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int BLK_W  = BLK_BYTES * IN_W;

  logic [IN_W-1:0]  mem_q [ROWS][BLK_BYTES];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ROW_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] data_q;
  logic             valid_q;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wr_acc, rd_acc;
  logic [ROW_W-1:0] wr_row;
  logic [LANE_W-1:0] wr_lane;
  logic [BLK_W-1:0] row_flat;
  logic [BLK_W-1:0] row_packed;

  assign o_full     = (cnt_q == CNT_W'(DEPTH));
  assign o_data_rdy = (cnt_q >= CNT_W'(BLK_BYTES));
  assign o_data_cnt = cnt_q;
  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_ovf      = ovf_q;
  assign o_udf      = udf_q;

  assign wr_acc  = i_wr_en & ~o_full & ~i_rst;
  assign rd_acc  = i_rd_en & o_data_rdy & ~i_rst;
  // Byte pointer splits into row (upper bits) and byte lane (lower bits).
  assign wr_row  = wr_ptr_q[PTR_W-1 -: ROW_W];
  assign wr_lane = wr_ptr_q[LANE_W-1:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_acc);
    rd_ptr_d = rd_ptr_q + ROW_W'(rd_acc);
    cnt_d    = cnt_q + CNT_W'(wr_acc) - (rd_acc ? CNT_W'(BLK_BYTES) : CNT_W'(0));
    ovf_d    = (ovf_q & ~i_clr_err) | (i_wr_en & o_full);
    udf_d    = (udf_q & ~i_clr_err) | (i_rd_en & ~o_data_rdy);
  end

  always_comb begin
    row_flat = '0;
    for (int k = 0; k < BLK_BYTES; k++) begin
      row_flat[IN_W*k +: IN_W] = mem_q[rd_ptr_q][k];
    end
  end

  block_fifo_pack #(
    .IN_W      (IN_W),
    .BLK_BYTES (BLK_BYTES),
    .GRP       (GRP)
  ) u_pack (
    .swap_i (i_swap),
    .row_i  (row_flat),
    .data_o (row_packed)
  );

  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      mem_q[wr_row][wr_lane] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      valid_q  <= rd_acc;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      if (rd_acc) begin
        data_q <= row_packed;
      end
    end
  end

endmodule

// File: tb/tb_block_fifo.sv
// tb/tb_block_fifo.sv - directed self-checking bench for block_fifo
module tb_block_fifo;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_wr_en = 1'b0;
  logic [7:0]   i_data = '0;
  logic         o_full;
  logic         i_rd_en = 1'b0;
  logic         i_swap = 1'b0;
  logic [511:0] o_data;
  logic         o_valid;
  logic         o_data_rdy;
  logic [8:0]   o_data_cnt;
  logic         i_clr_err = 1'b0;
  logic         o_ovf;
  logic         o_udf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  block_fifo dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr_en    (i_wr_en),
    .i_data     (i_data),
    .o_full     (o_full),
    .i_rd_en    (i_rd_en),
    .i_swap     (i_swap),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_data_rdy (o_data_rdy),
    .o_data_cnt (o_data_cnt),
    .i_clr_err  (i_clr_err),
    .o_ovf      (o_ovf),
    .o_udf      (o_udf)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] exp_blk(input logic [7:0] start, input logic swap);
    logic [511:0] r;
    int slot;
    r = '0;
    for (int k = 0; k < 64; k++) begin
      slot = swap ? ((k / 4) * 4 + 3 - (k % 4)) : k;
      r[8*slot +: 8] = start + 8'(k);
    end
    return r;
  endfunction

  task automatic wr_bytes(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      i_wr_en = 1'b1;
      i_data  = start + 8'(i);
      tick();
    end
    i_wr_en = 1'b0;
  endtask

  task automatic rd_blk(input logic swap);
    i_rd_en = 1'b1;
    i_swap  = swap;
    tick();
    i_rd_en = 1'b0;
    i_swap  = 1'b0;
  endtask

  initial begin
    logic [511:0] held;

    // Reset state
    tick();
    tick();
    i_rst = 1'b0;
    check("rst_cnt",   512'(o_data_cnt), 512'd0);
    check("rst_full",  512'(o_full),     512'd0);
    check("rst_rdy",   512'(o_data_rdy), 512'd0);
    check("rst_valid", 512'(o_valid),    512'd0);
    check("rst_data",  o_data,           512'd0);
    check("rst_flags", 512'({o_ovf, o_udf}), 512'd0);

    // Big-endian lane read of 0x00..0x3F
    wr_bytes(8'h00, 64);
    check("cnt64", 512'(o_data_cnt), 512'd64);
    check("rdy64", 512'(o_data_rdy), 512'd1);
    rd_blk(1'b1);
    check("swap1_valid", 512'(o_valid), 512'd1);
    check("swap1_lo",  512'(o_data[31:0]),    512'h00010203);
    check("swap1_hi",  512'(o_data[511:480]), 512'h3C3D3E3F);
    check("swap1_blk", o_data, exp_blk(8'h00, 1'b1));
    check("swap1_cnt", 512'(o_data_cnt), 512'd0);
    held = o_data;
    tick();
    check("valid_drop", 512'(o_valid), 512'd0);
    check("data_hold",  o_data, held);

    // Little-endian read of the same data
    wr_bytes(8'h00, 64);
    rd_blk(1'b0);
    check("swap0_lo",  512'(o_data[31:0]), 512'h03020100);
    check("swap0_blk", o_data, exp_blk(8'h00, 1'b0));

    // Fill to full, overflow, read one, clear
    wr_bytes(8'h00, 256);
    check("full_flag", 512'(o_full),     512'd1);
    check("full_cnt",  512'(o_data_cnt), 512'd256);
    wr_bytes(8'hAA, 1);
    check("ovf_cnt",  512'(o_data_cnt), 512'd256);
    check("ovf_flag", 512'(o_ovf),      512'd1);
    rd_blk(1'b0);
    check("after_rd_cnt",  512'(o_data_cnt), 512'd192);
    check("after_rd_full", 512'(o_full),     512'd0);
    check("after_rd_blk",  o_data, exp_blk(8'h00, 1'b0));
    check("ovf_sticky",    512'(o_ovf), 512'd1);
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    check("ovf_clr", 512'(o_ovf), 512'd0);
    rd_blk(1'b0);
    check("drain1", o_data, exp_blk(8'h40, 1'b0));
    rd_blk(1'b0);
    check("drain2", o_data, exp_blk(8'h80, 1'b0));
    rd_blk(1'b0);
    check("drain3", o_data, exp_blk(8'hC0, 1'b0));
    check("drain_cnt", 512'(o_data_cnt), 512'd0);

    // Underflow set wins over a same-cycle clear
    i_rd_en = 1'b1;
    i_clr_err = 1'b1;
    tick();
    i_rd_en = 1'b0;
    i_clr_err = 1'b0;
    check("udf_set_wins", 512'(o_udf), 512'd1);
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    check("udf_clr", 512'(o_udf), 512'd0);

    // Guarded read at count 63
    wr_bytes(8'h40, 63);
    rd_blk(1'b0);
    check("c63_valid", 512'(o_valid),    512'd0);
    check("c63_cnt",   512'(o_data_cnt), 512'd63);
    check("c63_udf",   512'(o_udf),      512'd1);
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;

    // Simultaneous write and read at count 64
    wr_bytes(8'h7F, 1);
    i_wr_en = 1'b1;
    i_data  = 8'h80;
    rd_blk(1'b0);
    i_wr_en = 1'b0;
    check("sim_valid", 512'(o_valid),    512'd1);
    check("sim_cnt",   512'(o_data_cnt), 512'd1);
    check("sim_blk",   o_data, exp_blk(8'h40, 1'b0));
    wr_bytes(8'h81, 63);
    rd_blk(1'b0);
    check("sim_kept", o_data, exp_blk(8'h80, 1'b0));

    // Pointer wrap over 5 rounds
    for (int r = 0; r < 5; r++) begin
      wr_bytes(8'(r * 64 + 8'h11), 64);
      rd_blk(r[0]);
      check($sformatf("wrap%0d", r), o_data, exp_blk(8'(r * 64 + 8'h11), r[0]));
    end

    // Mid-stream reset with inputs active
    i_rd_en = 1'b1;
    tick();
    i_rd_en = 1'b0;
    wr_bytes(8'h20, 100);
    check("pre_rst_cnt", 512'(o_data_cnt), 512'd100);
    i_rst = 1'b1;
    i_wr_en = 1'b1;
    i_rd_en = 1'b1;
    i_clr_err = 1'b0;
    tick();
    i_rst = 1'b0;
    i_wr_en = 1'b0;
    i_rd_en = 1'b0;
    check("mrst_cnt",   512'(o_data_cnt), 512'd0);
    check("mrst_data",  o_data,           512'd0);
    check("mrst_valid", 512'(o_valid),    512'd0);
    check("mrst_misc",  512'({o_full, o_data_rdy, o_ovf, o_udf}), 512'd0);
    wr_bytes(8'hC0, 64);
    rd_blk(1'b1);
    check("post_rst_blk", o_data, exp_blk(8'hC0, 1'b1));
    check("post_rst_cnt", 512'(o_data_cnt), 512'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
